// File: rtl/vector_activation_unit_if.sv
// Bus bundle for the vector activation unit: start/mode/mask/vector request
// from the producer side, activated vector, sparsity count and status back.
interface vector_activation_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 64
);
    logic                             start;
    logic [1:0]                       mode;
    logic [3:0]                       leaky_shift;
    logic [NUM_UNITS-1:0]             active_units;
    logic [DATA_WIDTH-1:0]            In_x [0:NUM_UNITS-1];
    logic [DATA_WIDTH-1:0]            Out  [0:NUM_UNITS-1];
    logic [$clog2(NUM_UNITS+1)-1:0]   zero_count;
    logic                             busy;
    logic                             ready;

    modport master (
        output start, mode, leaky_shift, active_units, In_x,
        input  Out, zero_count, busy, ready
    );

    modport slave (
        input  start, mode, leaky_shift, active_units, In_x,
        output Out, zero_count, busy, ready
    );
endinterface

// File: rtl/vector_activation_unit.sv
// Elementwise FP16 activation (pass / ReLU / leaky ReLU with 2^-shift slope)
// over a captured vector, LANES elements per beat, with a count of active
// elements that ReLU forced to +0.
module vector_activation_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 64,
    parameter int LANES      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_activation_unit_if.slave bus
);
    localparam int BEATS  = NUM_UNITS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CNT_W  = $clog2(NUM_UNITS + 1);
    localparam int LCNT_W = $clog2(LANES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  busy_q;
    logic                  ready_q;
    logic [CNT_W-1:0]      zc_q;
    logic [DATA_WIDTH-1:0] out_q  [0:NUM_UNITS-1];
    logic [DATA_WIDTH-1:0] x_q    [0:NUM_UNITS-1];
    logic [NUM_UNITS-1:0]  mask_q;
    logic [1:0]            mode_q;
    logic [3:0]            shift_q;

    logic [16:0]           lane_res_d [0:LANES-1];
    logic [LCNT_W-1:0]     chunk_zc_d;
    logic                  accept;

    // Returns {zeroed_by_relu, result}. Leaky scaling by 2^-shift is an
    // exponent subtract; anything that would drop to exp<=0 flushes to -0.
    function automatic logic [16:0] activate(
        input logic [15:0] x,
        input logic        en,
        input logic [1:0]  mode,
        input logic [3:0]  shift
    );
        logic [4:0] e;
        logic       is_nan;
        logic [16:0] res;
        e      = x[14:10];
        is_nan = (e == 5'd31) && (x[9:0] != 10'd0);
        res    = {1'b0, x};
        if (!en) begin
            res = 17'd0;
        end else if (is_nan) begin
            res = {1'b0, x};
        end else if (mode == 2'd1) begin
            if (x[15]) res = {1'b1, 16'h0000};
        end else if (mode == 2'd2) begin
            if (x[15]) begin
                if (e == 5'd31)
                    res = {1'b0, 16'hFC00};
                else if (e > {1'b0, shift})
                    res = {1'b0, 1'b1, e - {1'b0, shift}, x[9:0]};
                else
                    res = {1'b0, 16'h8000};
            end
        end
        return res;
    endfunction

    assign accept = (state_q == IDLE) && bus.start;

    // Activate the chunk selected by the current beat and count its zeroes.
    always_comb begin
        chunk_zc_d = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_res_d[l] = activate(x_q[IDX_W'(int'(beat_q) * LANES + l)],
                                     mask_q[IDX_W'(int'(beat_q) * LANES + l)],
                                     mode_q, shift_q);
            chunk_zc_d = chunk_zc_d + LCNT_W'(lane_res_d[l][16]);
        end
    end

    // Control FSM: accept in IDLE, walk BEATS chunks in RUN, raise ready at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            zc_q    <= '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                state_q <= RUN;
                beat_q  <= '0;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
                zc_q    <= '0;
            end
        end else begin
            zc_q <= zc_q + CNT_W'(chunk_zc_d);
            if (beat_q == BEAT_W'(BEATS - 1)) begin
                state_q <= IDLE;
                beat_q  <= '0;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // Operand capture at accept so later input changes cannot disturb the run.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q     <= bus.In_x;
            mask_q  <= bus.active_units;
            mode_q  <= bus.mode;
            shift_q <= bus.leaky_shift;
        end
    end

    // Result vector: cleared on reset, one chunk written per RUN beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_UNITS; i++) out_q[i] <= '0;
        end else if (state_q == RUN) begin
            for (int l = 0; l < LANES; l++)
                out_q[IDX_W'(int'(beat_q) * LANES + l)] <= lane_res_d[l][15:0];
        end
    end

    assign bus.Out        = out_q;
    assign bus.zero_count = zc_q;
    assign bus.busy       = busy_q;
    assign bus.ready      = ready_q;
endmodule
